// File: rtl/scan_rw_ctrl_pkg.sv
// Shared types for the scan read/write controller: FSM states, the queued
// request layout and the bit positions inside the sticky error flags.
package scan_rw_pkg;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 32;

  localparam int ERR_TIMEOUT = 0;
  localparam int ERR_OVF     = 1;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } state_t;

  // One queued scan access; is_wr=0 means a read.
  typedef struct packed {
    logic              is_wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  localparam int REQ_W = $bits(req_t);

endpackage

// File: rtl/scan_rw_ctrl_if.sv
// Static-register side and mem/reg mux side of the scan read/write controller,
// bundled so the controller and its environment share one connection.
interface scan_rw_ctrl_if #(
  parameter int ADDR_W     = scan_rw_pkg::ADDR_W,
  parameter int DATA_W     = scan_rw_pkg::DATA_W,
  parameter int FIFO_DEPTH = 4,
  localparam int LEVEL_W   = $clog2(FIFO_DEPTH + 1)
);

  logic               id_valid;
  logic               static_wen;
  logic               static_ren;
  logic [ADDR_W-1:0]  static_addr;
  logic [DATA_W-1:0]  static_wdata;
  logic               err_clr;
  logic               static_ready;
  logic [DATA_W-1:0]  static_rdata;
  logic               static_resp;
  logic [1:0]         static_err;
  logic [LEVEL_W-1:0] level;

  logic               scan_wen;
  logic               scan_ren;
  logic [ADDR_W-1:0]  scan_addr;
  logic [DATA_W-1:0]  scan_wdata;
  logic [DATA_W-1:0]  scan_rdata;
  logic               scan_ready;

  modport master (
    input  id_valid, static_wen, static_ren, static_addr, static_wdata, err_clr,
    input  scan_rdata, scan_ready,
    output static_ready, static_rdata, static_resp, static_err, level,
    output scan_wen, scan_ren, scan_addr, scan_wdata
  );

  modport slave (
    output id_valid, static_wen, static_ren, static_addr, static_wdata, err_clr,
    output scan_rdata, scan_ready,
    input  static_ready, static_rdata, static_resp, static_err, level,
    input  scan_wen, scan_ren, scan_addr, scan_wdata
  );

endinterface

// File: rtl/scan_rw_ctrl_req_fifo.sv
// Request queue for the scan controller. Power-of-two depth; the pointers
// carry one extra wrap bit so full and empty are told apart without a counter.
module scan_req_fifo #(
  parameter int WIDTH = 45,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_push,
  input  logic [WIDTH-1:0]       i_data,
  input  logic                   i_pop,
  output logic [WIDTH-1:0]       o_data,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_level
);

  localparam int IDX_W = $clog2(DEPTH);

  logic [IDX_W:0]   r_wptr;
  logic [IDX_W:0]   r_rptr;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             w_push;
  logic             w_pop;

  // A push into a full queue is accepted only when a pop frees the head slot
  // in the same cycle.
  assign w_pop   = i_pop & ~o_empty;
  assign w_push  = i_push & (~o_full | w_pop);
  assign o_empty = (r_wptr == r_rptr);
  assign o_full  = (r_wptr[IDX_W] != r_rptr[IDX_W]) &&
                   (r_wptr[IDX_W-1:0] == r_rptr[IDX_W-1:0]);
  assign o_level = r_wptr - r_rptr;
  assign o_data  = r_mem[r_rptr[IDX_W-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr[IDX_W-1:0]] <= i_data;
  end

endmodule

// File: rtl/scan_rw_ctrl.sv
// Scan read/write controller: queues requests from the static register side
// and replays them one at a time to the mem/reg mux, with a completion timeout.
module scan_rw_ctrl
  import scan_rw_pkg::*;
#(
  parameter int ADDR_W     = scan_rw_pkg::ADDR_W,
  parameter int DATA_W     = scan_rw_pkg::DATA_W,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 255
) (
  input logic            clk,
  input logic            rst,
  scan_rw_ctrl_if.master bus
);

  localparam int CNT_W   = $clog2(TIMEOUT + 1);
  localparam int LEVEL_W = $clog2(FIFO_DEPTH + 1);

  state_t             r_state;
  state_t             w_state_nxt;
  req_t               r_hold;
  req_t               w_push_req;
  req_t               w_head;
  logic               r_id_valid_q;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_scan_wen;
  logic               r_scan_ren;
  logic [ADDR_W-1:0]  r_scan_addr;
  logic [DATA_W-1:0]  r_scan_wdata;
  logic [DATA_W-1:0]  r_rdata;
  logic               r_resp;
  logic               r_ready;
  logic [1:0]         r_err;
  logic [1:0]         w_err_set;
  logic               w_edge;
  logic               w_push;
  logic               w_pop;
  logic               w_full;
  logic               w_empty;
  logic               w_done;
  logic               w_abort;
  logic [LEVEL_W-1:0] w_level;

  // Only a rising edge of id_valid with exactly one of wen/ren is a request;
  // anything else seen on an edge is flagged as an overflow/illegal request.
  assign w_edge     = bus.id_valid & ~r_id_valid_q;
  assign w_pop      = (r_state == IDLE) & ~w_empty;
  assign w_push     = w_edge & (bus.static_wen ^ bus.static_ren) & (~w_full | w_pop);
  assign w_push_req = '{is_wr: bus.static_wen, addr: bus.static_addr, wdata: bus.static_wdata};

  scan_req_fifo #(
    .WIDTH (REQ_W),
    .DEPTH (FIFO_DEPTH)
  ) u_req_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  (w_push_req),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (w_level)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_done      = 1'b0;
    w_abort     = 1'b0;
    unique case (r_state)
      IDLE:  if (!w_empty) w_state_nxt = ISSUE;
      ISSUE: w_state_nxt = WAIT;
      WAIT: begin
        if (bus.scan_ready) begin
          w_done      = 1'b1;
          w_state_nxt = IDLE;
        end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
          w_abort     = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_err_set              = '0;
    w_err_set[ERR_TIMEOUT] = w_abort;
    w_err_set[ERR_OVF]     = w_edge & ~w_push;
  end

  // The strobe registers load from the holding register while in ISSUE, so
  // the strobe is visible during the first WAIT cycle and is zero elsewhere.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_id_valid_q <= 1'b0;
      r_hold       <= '0;
      r_cnt        <= '0;
      r_scan_wen   <= 1'b0;
      r_scan_ren   <= 1'b0;
      r_scan_addr  <= '0;
      r_scan_wdata <= '0;
      r_rdata      <= '0;
      r_resp       <= 1'b0;
      r_err        <= '0;
      r_ready      <= 1'b1;
    end else begin
      r_state      <= w_state_nxt;
      r_id_valid_q <= bus.id_valid;
      if (w_pop) r_hold <= w_head;
      r_scan_wen   <= (r_state == ISSUE) &  r_hold.is_wr;
      r_scan_ren   <= (r_state == ISSUE) & ~r_hold.is_wr;
      r_scan_addr  <= (r_state == ISSUE) ? r_hold.addr  : '0;
      r_scan_wdata <= (r_state == ISSUE) ? r_hold.wdata : '0;
      if (r_state == ISSUE) r_cnt <= '0;
      else if (r_state == WAIT && !bus.scan_ready) r_cnt <= r_cnt + 1'b1;
      r_resp <= w_done | w_abort;
      if (w_done && !r_hold.is_wr) r_rdata <= bus.scan_rdata;
      else if (w_abort && !r_hold.is_wr) r_rdata <= '1;
      r_err   <= (bus.err_clr ? 2'b00 : r_err) | w_err_set;
      r_ready <= (w_state_nxt == IDLE) & w_empty & ~w_push;
    end
  end

  assign bus.scan_wen     = r_scan_wen;
  assign bus.scan_ren     = r_scan_ren;
  assign bus.scan_addr    = r_scan_addr;
  assign bus.scan_wdata   = r_scan_wdata;
  assign bus.static_rdata = r_rdata;
  assign bus.static_resp  = r_resp;
  assign bus.static_err   = r_err;
  assign bus.static_ready = r_ready;
  assign bus.level        = w_level;

endmodule

// File: tb/tb_scan_rw_ctrl.sv
// Directed bench for scan_rw_ctrl: single write/read, queue fill and overflow,
// illegal and held requests, timeout abort, and reset during an access.
module tb_scan_rw_ctrl;

  logic clk = 1'b0;
  logic rst;
  int   compCount = 0;
  int   errCount  = 0;
  int   wenCount  = 0;
  int   renCount  = 0;
  int   respCount = 0;
  logic [11:0] strobeAddr [$];
  logic        strobeWr [$];

  scan_rw_ctrl_if #(.ADDR_W(12), .DATA_W(32), .FIFO_DEPTH(4)) bus ();

  scan_rw_ctrl #(
    .ADDR_W     (12),
    .DATA_W     (32),
    .FIFO_DEPTH (4),
    .TIMEOUT    (255)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  always #5 clk = ~clk;

  // Pulse counters and strobe log, sampled just after each rising edge.
  always begin
    @(posedge clk);
    #1;
    if (bus.scan_wen) wenCount++;
    if (bus.scan_ren) renCount++;
    if (bus.static_resp) respCount++;
    if (bus.scan_wen || bus.scan_ren) begin
      strobeAddr.push_back(bus.scan_addr);
      strobeWr.push_back(bus.scan_wen);
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: observed no finish expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    compCount++;
    assert (observed === expected) else begin
      errCount++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Raises id_valid with the given request for one clock edge, then drops it.
  task automatic applyStimulus(input logic wen, input logic ren, input logic [11:0] addr, input logic [31:0] wdata);
    bus.static_wen   = wen;
    bus.static_ren   = ren;
    bus.static_addr  = addr;
    bus.static_wdata = wdata;
    bus.id_valid     = 1'b1;
    tick();
    bus.id_valid   = 1'b0;
    bus.static_wen = 1'b0;
    bus.static_ren = 1'b0;
  endtask

  initial begin
    int wenBase;
    int renBase;
    int respBase;

    rst              = 1'b1;
    bus.id_valid     = 1'b0;
    bus.static_wen   = 1'b0;
    bus.static_ren   = 1'b0;
    bus.static_addr  = '0;
    bus.static_wdata = '0;
    bus.err_clr      = 1'b0;
    bus.scan_rdata   = '0;
    bus.scan_ready   = 1'b0;
    tick(3);

    checkOutput("rst_ready", bus.static_ready, 1);
    checkOutput("rst_rdata", bus.static_rdata, 0);
    checkOutput("rst_resp", bus.static_resp, 0);
    checkOutput("rst_err", bus.static_err, 0);
    checkOutput("rst_level", bus.level, 0);
    checkOutput("rst_wen", bus.scan_wen, 0);
    checkOutput("rst_ren", bus.scan_ren, 0);
    checkOutput("rst_addr", bus.scan_addr, 0);
    rst = 1'b0;
    tick();

    $display("[TB] single write");
    applyStimulus(1'b1, 1'b0, 12'h3A5, 32'hDEADBEEF);
    checkOutput("wr_level_captured", bus.level, 1);
    checkOutput("wr_ready_low", bus.static_ready, 0);
    tick();
    checkOutput("wr_level_popped", bus.level, 0);
    checkOutput("wr_no_early_strobe", bus.scan_wen, 0);
    tick();
    checkOutput("wr_strobe", bus.scan_wen, 1);
    checkOutput("wr_no_ren", bus.scan_ren, 0);
    checkOutput("wr_addr", bus.scan_addr, 12'h3A5);
    checkOutput("wr_wdata", bus.scan_wdata, 32'hDEADBEEF);
    tick();
    checkOutput("wr_strobe_drop", bus.scan_wen, 0);
    checkOutput("wr_addr_zero", bus.scan_addr, 0);
    checkOutput("wr_busy", bus.static_ready, 0);
    tick(2);
    bus.scan_ready = 1'b1;
    tick();
    checkOutput("wr_resp", bus.static_resp, 1);
    checkOutput("wr_rdata_kept", bus.static_rdata, 0);
    checkOutput("wr_ready_back", bus.static_ready, 1);
    bus.scan_ready = 1'b0;
    tick();
    checkOutput("wr_resp_one_cycle", bus.static_resp, 0);
    checkOutput("wr_strobe_count", wenCount, 1);

    $display("[TB] single read, ready held through ISSUE");
    bus.scan_rdata = 32'h12345678;
    bus.scan_ready = 1'b1;
    applyStimulus(1'b0, 1'b1, 12'h010, 32'h0);
    tick(2);
    checkOutput("rd_strobe", bus.scan_ren, 1);
    checkOutput("rd_addr", bus.scan_addr, 12'h010);
    checkOutput("rd_no_resp_in_issue", bus.static_resp, 0);
    tick();
    checkOutput("rd_strobe_drop", bus.scan_ren, 0);
    checkOutput("rd_resp", bus.static_resp, 1);
    checkOutput("rd_rdata", bus.static_rdata, 32'h12345678);
    bus.scan_ready = 1'b0;
    tick();
    checkOutput("rd_resp_one_cycle", bus.static_resp, 0);
    checkOutput("rd_strobe_count", renCount, 1);

    $display("[TB] queue fill, overflow, timeouts in order");
    strobeAddr.delete();
    strobeWr.delete();
    respBase = respCount;
    for (int k = 0; k < 5; k++) begin
      applyStimulus(logic'(k != 1), logic'(k == 1), 12'(12'h100 + k), 32'(32'h1000 + k));
      tick();
    end
    checkOutput("fill_level", bus.level, 4);
    checkOutput("fill_err", bus.static_err, 0);
    checkOutput("fill_busy", bus.static_ready, 0);
    applyStimulus(1'b1, 1'b0, 12'h1FF, 32'h0);
    checkOutput("ovf_level", bus.level, 4);
    checkOutput("ovf_err", bus.static_err, 2'b10);
    for (int i = 0; i < 2000 && respCount < respBase + 5; i++) tick();
    checkOutput("fill_resp_count", respCount - respBase, 5);
    checkOutput("fill_strobe_count", strobeAddr.size(), 5);
    for (int k = 0; k < 5; k++) begin
      checkOutput($sformatf("fill_order_addr%0d", k), strobeAddr[k], 12'(12'h100 + k));
      checkOutput($sformatf("fill_order_wr%0d", k), strobeWr[k], logic'(k != 1));
    end
    checkOutput("fill_err_both", bus.static_err, 2'b11);
    checkOutput("fill_rdata_abort", bus.static_rdata, 32'hFFFFFFFF);
    checkOutput("fill_drained", bus.level, 0);
    checkOutput("fill_ready_back", bus.static_ready, 1);

    $display("[TB] illegal request with err_clr, held id_valid");
    wenBase = wenCount;
    renBase = renCount;
    bus.err_clr = 1'b1;
    applyStimulus(1'b1, 1'b1, 12'h066, 32'h66);
    bus.err_clr = 1'b0;
    checkOutput("ill_level", bus.level, 0);
    checkOutput("ill_err_set_wins", bus.static_err, 2'b10);
    tick(4);
    checkOutput("ill_no_wen", wenCount - wenBase, 0);
    checkOutput("ill_no_ren", renCount - renBase, 0);
    checkOutput("ill_ready", bus.static_ready, 1);
    respBase = respCount;
    bus.scan_rdata   = 32'hCAFE0005;
    bus.scan_ready   = 1'b1;
    bus.static_ren   = 1'b1;
    bus.static_addr  = 12'h077;
    bus.id_valid     = 1'b1;
    tick(10);
    bus.id_valid   = 1'b0;
    bus.static_ren = 1'b0;
    tick(6);
    checkOutput("held_one_read", renCount - renBase, 1);
    checkOutput("held_one_resp", respCount - respBase, 1);
    checkOutput("held_rdata", bus.static_rdata, 32'hCAFE0005);
    checkOutput("held_err_kept", bus.static_err, 2'b10);
    bus.scan_ready = 1'b0;
    bus.err_clr = 1'b1;
    tick();
    bus.err_clr = 1'b0;
    checkOutput("clr_err", bus.static_err, 0);

    $display("[TB] read timeout");
    applyStimulus(1'b0, 1'b1, 12'h055, 32'h0);
    tick(256);
    checkOutput("to_no_resp_early", bus.static_resp, 0);
    checkOutput("to_rdata_early", bus.static_rdata, 32'hCAFE0005);
    tick();
    checkOutput("to_resp", bus.static_resp, 1);
    checkOutput("to_rdata", bus.static_rdata, 32'hFFFFFFFF);
    checkOutput("to_err", bus.static_err, 2'b01);
    bus.err_clr = 1'b1;
    tick();
    bus.err_clr = 1'b0;
    checkOutput("to_err_clr", bus.static_err, 0);
    checkOutput("to_resp_one_cycle", bus.static_resp, 0);

    $display("[TB] reset during WAIT");
    applyStimulus(1'b1, 1'b0, 12'h0AA, 32'h0AA);
    tick();
    applyStimulus(1'b1, 1'b0, 12'h0BB, 32'h0BB);
    tick(2);
    checkOutput("mid_level", bus.level, 1);
    rst = 1'b1;
    tick();
    checkOutput("mid_rst_ready", bus.static_ready, 1);
    checkOutput("mid_rst_rdata", bus.static_rdata, 0);
    checkOutput("mid_rst_resp", bus.static_resp, 0);
    checkOutput("mid_rst_level", bus.level, 0);
    checkOutput("mid_rst_wen", bus.scan_wen, 0);
    checkOutput("mid_rst_wdata", bus.scan_wdata, 0);
    rst = 1'b0;
    wenBase  = wenCount;
    respBase = respCount;
    tick(20);
    checkOutput("mid_no_resp", respCount - respBase, 0);
    checkOutput("mid_flushed", wenCount - wenBase, 0);
    bus.scan_ready = 1'b1;
    applyStimulus(1'b1, 1'b0, 12'h0CC, 32'h0CC);
    tick(4);
    bus.scan_ready = 1'b0;
    checkOutput("post_rst_wen", wenCount - wenBase, 1);
    checkOutput("post_rst_resp", respCount - respBase, 1);
    checkOutput("post_rst_ready", bus.static_ready, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compCount, errCount);
    $finish;
  end

endmodule
